// File: rtl/gb_ppu_bg_fetcher_if.sv
// ---------------------------------------------------------------------------
// gb_ppu_bg_fetcher_if
// Bus bundle between the background fetcher and its neighbours.
//   vram_addr  : VRAM read address (0x0000 whenever vram_rd is low)
//   vram_rd    : fetcher owns the VRAM bus this cycle
//   vram_data  : VRAM read data, combinational from vram_addr
//   fifo_ready : BG FIFO can accept an 8-pixel row this cycle
//   push       : 8-pixel row valid and accepted this cycle
//   px         : 2bpp pixel row, leftmost pixel in px[15:14]
// master = fetcher side, slave = VRAM mux / BG FIFO side.
// ---------------------------------------------------------------------------
interface gb_ppu_bg_fetcher_if;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic        fifo_ready;
  logic        push;
  logic [15:0] px;

  modport master (
    output vram_addr,
    output vram_rd,
    output push,
    output px,
    input  vram_data,
    input  fifo_ready
  );

  modport slave (
    input  vram_addr,
    input  vram_rd,
    input  push,
    input  px,
    output vram_data,
    output fifo_ready
  );
endinterface

// File: rtl/gb_ppu_bg_fetcher.sv
// ---------------------------------------------------------------------------
// gb_ppu_bg_fetcher
// Background tile fetcher for PPU Mode 3. Each line it walks NUM_TILES
// columns of the selected tile map, reads tile number, low plane and high
// plane over VRAM, then hands the 8-pixel row to the BG FIFO.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_start           : one-cycle pulse, begin a line (honoured only in IDLE)
//   i_ly/i_scx/i_scy  : scanline and scroll, sampled at start
//   i_map_sel         : 0 = map at 0x9800, 1 = map at 0x9C00
//   i_data_sel        : 1 = unsigned tiles at 0x8000, 0 = signed at 0x9000
//   bus (master)      : VRAM read port and BG FIFO push port
//   o_busy            : fetcher is not idle
//   o_done            : one-cycle pulse after the final push of the line
// ---------------------------------------------------------------------------
module gb_ppu_bg_fetcher #(
  parameter int NUM_TILES = 21
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [7:0]                 i_ly,
  input  logic [7:0]                 i_scx,
  input  logic [7:0]                 i_scy,
  input  logic                       i_map_sel,
  input  logic                       i_data_sel,
  gb_ppu_bg_fetcher_if.master        bus,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TILE_NUM = 3'd1,
    S_DATA_LO  = 3'd2,
    S_DATA_HI  = 3'd3,
    S_PUSH     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [4:0] LP_LAST_X = 5'(NUM_TILES - 1);

  // Interleave the two bit planes: pixel i = {hi[7-i], lo[7-i]}.
  function automatic logic [15:0] f_pixels(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] row;
    row = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      row[15 - 2*i] = hi[7 - i];
      row[14 - 2*i] = lo[7 - i];
    end
    return row;
  endfunction

  // VRAM address presented while sitting in a given state.
  function automatic logic [15:0] f_addr(
    input state_t     st,
    input logic [7:0] y,
    input logic [4:0] scx_tile,
    input logic [4:0] fetch_x,
    input logic [7:0] tile_num,
    input logic       map_sel,
    input logic       data_sel
  );
    logic [4:0]  col;
    logic [15:0] map_base;
    logic [15:0] tile_base;
    logic [15:0] addr;
    // Column wraps inside the 32-wide map, so the index never leaves it.
    col       = scx_tile + fetch_x;
    map_base  = map_sel ? 16'h9C00 : 16'h9800;
    // Signed mode: sign-extended tile number times 16, wrapping in 16 bits,
    // lands in 0x8800..0x97F0 around the 0x9000 base.
    tile_base = data_sel ? (16'h8000 + {4'h0, tile_num, 4'h0})
                         : (16'h9000 + {{4{tile_num[7]}}, tile_num, 4'h0});
    case (st)
      S_TILE_NUM: addr = map_base + {6'd0, y[7:3], col};
      S_DATA_LO:  addr = tile_base + {12'd0, y[2:0], 1'b0};
      S_DATA_HI:  addr = tile_base + {12'd0, y[2:0], 1'b1};
      default:    addr = 16'h0000;
    endcase
    return addr;
  endfunction

  state_t      r_state;
  logic [7:0]  r_y;
  logic [4:0]  r_scx_tile;
  logic        r_map_sel;
  logic        r_data_sel;
  logic [4:0]  r_fetch_x;
  logic [7:0]  r_tile_num;
  logic [7:0]  r_lo;
  logic [7:0]  r_hi;
  logic [15:0] r_vram_addr;
  logic        r_vram_rd;
  logic [15:0] r_px;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [7:0]  w_y_nxt;
  logic [4:0]  w_scx_tile_nxt;
  logic        w_map_sel_nxt;
  logic        w_data_sel_nxt;
  logic [4:0]  w_fetch_x_nxt;
  logic [7:0]  w_tile_num_nxt;
  logic [7:0]  w_lo_nxt;
  logic [7:0]  w_hi_nxt;
  logic        w_unused_fine_x;

  // Fine X discard belongs to the FIFO; only the coarse column is used here.
  assign w_unused_fine_x = ^i_scx[2:0];

  // Next-state and next-datapath values for the line walk.
  always_comb begin
    w_state_nxt    = r_state;
    w_y_nxt        = r_y;
    w_scx_tile_nxt = r_scx_tile;
    w_map_sel_nxt  = r_map_sel;
    w_data_sel_nxt = r_data_sel;
    w_fetch_x_nxt  = r_fetch_x;
    w_tile_num_nxt = r_tile_num;
    w_lo_nxt       = r_lo;
    w_hi_nxt       = r_hi;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_TILE_NUM;
          w_y_nxt        = i_ly + i_scy;
          w_scx_tile_nxt = i_scx[7:3];
          w_map_sel_nxt  = i_map_sel;
          w_data_sel_nxt = i_data_sel;
          w_fetch_x_nxt  = 5'd0;
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end
      S_TILE_NUM: begin
        w_tile_num_nxt = bus.vram_data;
        w_state_nxt    = S_DATA_LO;
      end
      S_DATA_LO: begin
        w_lo_nxt    = bus.vram_data;
        w_state_nxt = S_DATA_HI;
      end
      S_DATA_HI: begin
        w_hi_nxt    = bus.vram_data;
        w_state_nxt = S_PUSH;
      end
      S_PUSH: begin
        if (!bus.fifo_ready) begin
          w_state_nxt = S_PUSH;
        end else if (r_fetch_x == LP_LAST_X) begin
          w_state_nxt = S_DONE;
        end else begin
          w_fetch_x_nxt = r_fetch_x + 5'd1;
          w_state_nxt   = S_TILE_NUM;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, line registers and registered outputs; outputs are computed from
  // the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_y         <= 8'h00;
      r_scx_tile  <= 5'd0;
      r_map_sel   <= 1'b0;
      r_data_sel  <= 1'b0;
      r_fetch_x   <= 5'd0;
      r_tile_num  <= 8'h00;
      r_lo        <= 8'h00;
      r_hi        <= 8'h00;
      r_vram_addr <= 16'h0000;
      r_vram_rd   <= 1'b0;
      r_px        <= 16'h0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_scx_tile  <= w_scx_tile_nxt;
      r_map_sel   <= w_map_sel_nxt;
      r_data_sel  <= w_data_sel_nxt;
      r_fetch_x   <= w_fetch_x_nxt;
      r_tile_num  <= w_tile_num_nxt;
      r_lo        <= w_lo_nxt;
      r_hi        <= w_hi_nxt;
      r_vram_addr <= f_addr(w_state_nxt, w_y_nxt, w_scx_tile_nxt, w_fetch_x_nxt,
                            w_tile_num_nxt, w_map_sel_nxt, w_data_sel_nxt);
      r_vram_rd   <= (w_state_nxt == S_TILE_NUM) || (w_state_nxt == S_DATA_LO) ||
                     (w_state_nxt == S_DATA_HI);
      r_px        <= f_pixels(w_hi_nxt, w_lo_nxt);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.vram_addr = r_vram_addr;
  assign bus.vram_rd   = r_vram_rd;
  assign bus.px        = r_px;
  // The FIFO accepts in the same cycle it signals ready.
  assign bus.push      = (r_state == S_PUSH) && bus.fifo_ready;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule

// File: tb/tb_gb_ppu_bg_fetcher.sv
// ---------------------------------------------------------------------------
// tb_gb_ppu_bg_fetcher
// Self-checking bench: table of directed lines, a reset-mid-fetch sequence
// and randomized lines, all compared cycle by cycle to a timeline model.
// ---------------------------------------------------------------------------
module tb_gb_ppu_bg_fetcher;
  localparam int N   = 21;
  localparam int LIM = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ly, scx, scy;
  logic       map_sel, data_sel;
  logic       busy, done;

  always #5 clk = ~clk;

  gb_ppu_bg_fetcher_if bus();

  gb_ppu_bg_fetcher #(.NUM_TILES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .i_ly       (ly),
    .i_scx      (scx),
    .i_scy      (scy),
    .i_map_sel  (map_sel),
    .i_data_sel (data_sel),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done)
  );

  // VRAM image for 0x8000..0x9FFF, read combinationally.
  logic [7:0] mem [0:8191];
  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    if (bus.vram_addr[15:13] == 3'b100) rdata = mem[bus.vram_addr[12:0]];
  end
  assign bus.vram_data = rdata;

  // Expected timeline, indexed by cycle offset after the start edge.
  bit          exp_rd   [LIM];
  logic [15:0] exp_addr [LIM];
  bit          exp_push [LIM];
  bit          exp_pxv  [LIM];
  logic [15:0] exp_px   [LIM];
  bit          exp_done [LIM];
  bit          exp_busy [LIM];
  bit          ready_pat[LIM];
  int          exp_done_c;

  logic [15:0] obs_reads[$];
  logic [15:0] obs_px[$];
  int          obs_busy_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic int mrd(input int a);
    return int'(mem[(a - 32'h8000) & 8191]);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a[12:0]] = d;
  endtask

  task automatic set_ready(input int stall, input bit rnd);
    for (int c = 0; c < LIM; c++)
      ready_pat[c] = rnd ? (c >= 300 || $urandom_range(3) != 0) : !(c >= 3 && c < 3 + stall);
  endtask

  // Line schedule from the fetch rules: 3 reads per tile, push at the first
  // ready cycle after them, done one cycle after the last push.
  task automatic build_model(input int l, input int sx, input int sy, input bit ms, input bit ds);
    int y, row, fy, c, col, ma, tn, base, la, lo, hi, p;
    for (int i = 0; i < LIM; i++) begin
      exp_rd[i] = 0; exp_addr[i] = 16'h0000; exp_push[i] = 0;
      exp_pxv[i] = 0; exp_px[i] = 16'h0000; exp_done[i] = 0; exp_busy[i] = 0;
    end
    y   = (l + sy) % 256;
    row = y / 8;
    fy  = y % 8;
    c   = 0;
    for (int fx = 0; fx < N; fx++) begin
      col  = (sx / 8 + fx) % 32;
      ma   = (ms ? 32'h9C00 : 32'h9800) + row * 32 + col;
      tn   = mrd(ma);
      base = ds ? 32'h8000 + tn * 16 : 32'h9000 + ((tn >= 128) ? tn - 256 : tn) * 16;
      la   = base + fy * 2;
      lo   = mrd(la);
      hi   = mrd(la + 1);
      p    = 0;
      for (int i = 0; i < 8; i++)
        p += (((hi >> (7 - i)) & 1) << (15 - 2*i)) + (((lo >> (7 - i)) & 1) << (14 - 2*i));
      exp_rd[c] = 1;     exp_addr[c] = 16'(ma);
      exp_rd[c+1] = 1;   exp_addr[c+1] = 16'(la);
      exp_rd[c+2] = 1;   exp_addr[c+2] = 16'(la + 1);
      c += 3;
      while (!ready_pat[c]) begin
        exp_pxv[c] = 1; exp_px[c] = 16'(p); c++;
      end
      exp_push[c] = 1; exp_pxv[c] = 1; exp_px[c] = 16'(p); c++;
    end
    exp_done[c] = 1;
    exp_done_c  = c;
    for (int i = 0; i <= c; i++) exp_busy[i] = 1;
  endtask

  task automatic run_line(input int l, input int sx, input int sy, input bit ms, input bit ds,
                          input int start_mid, input bit scramble, input bit pre_started,
                          input string tag);
    build_model(l, sx, sy, ms, ds);
    obs_reads.delete();
    obs_px.delete();
    obs_busy_cnt = 0;
    if (!pre_started) begin
      @(posedge clk); #1;
      start = 1'b1; ly = 8'(l); scx = 8'(sx); scy = 8'(sy); map_sel = ms; data_sel = ds;
    end
    for (int c = 0; c <= exp_done_c + 2; c++) begin
      @(posedge clk); #1;
      start = (c == start_mid);
      bus.fifo_ready = ready_pat[c];
      if (scramble) begin
        ly = 8'($urandom); scx = 8'($urandom); scy = 8'($urandom);
        map_sel = 1'($urandom); data_sel = 1'($urandom);
      end
      @(negedge clk);
      chk({tag, ".rd"},   32'(bus.vram_rd),   32'(exp_rd[c]));
      chk({tag, ".addr"}, 32'(bus.vram_addr), 32'(exp_addr[c]));
      chk({tag, ".push"}, 32'(bus.push),      32'(exp_push[c]));
      chk({tag, ".busy"}, 32'(busy),          32'(exp_busy[c]));
      chk({tag, ".done"}, 32'(done),          32'(exp_done[c]));
      if (exp_pxv[c]) chk({tag, ".px"}, 32'(bus.px), 32'(exp_px[c]));
      if (bus.vram_rd) obs_reads.push_back(bus.vram_addr);
      if (bus.push)    obs_px.push_back(bus.px);
      if (busy)        obs_busy_cnt++;
    end
    start = 1'b0;
    bus.fifo_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  ly, scx, scy;
    bit          ms, ds;
    int          stall;
    logic [15:0] pa0, pa1, pa2;
    logic [7:0]  pd0, pd1, pd2;
    logic [15:0] ea0, ea1, ea2, ea3;
    logic [15:0] epx;
    int          ecyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0, 16'h9800, 16'h8010, 16'h8011,
                8'h01, 8'hF0, 8'hCC, 16'h9800, 16'h8010, 16'h8011, 16'h9801, 16'hF5A0, 85};
    vecs[1] = '{8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 0, 16'h9800, 16'h8806, 16'h8807,
                8'h80, 8'h0F, 8'hFF, 16'h9800, 16'h8806, 16'h8807, 16'h9801, 16'hAAFF, 85};
    vecs[2] = '{8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 0, 16'h9800, 16'h97F6, 16'h97F7,
                8'h7F, 8'h81, 8'h01, 16'h9800, 16'h97F6, 16'h97F7, 16'h9801, 16'h4003, 85};
    vecs[3] = '{8'hFE, 8'hF8, 8'h05, 1'b1, 1'b1, 0, 16'h9C1F, 16'h8026, 16'h8027,
                8'h02, 8'hFF, 8'h00, 16'h9C1F, 16'h8026, 16'h8027, 16'h9C00, 16'h5555, 85};
    vecs[4] = '{8'h10, 8'h20, 8'h00, 1'b0, 1'b1, 5, 16'h9844, 16'h8000, 16'h8001,
                8'h00, 8'hAA, 8'h55, 16'h9844, 16'h8000, 16'h8001, 16'h9845, 16'h6666, 90};
    vecs[5] = '{8'h07, 8'h00, 8'h00, 1'b0, 1'b1, 0, 16'h9800, 16'h8FFE, 16'h8FFF,
                8'hFF, 8'h00, 8'hFF, 16'h9800, 16'h8FFE, 16'h8FFF, 16'h9801, 16'hAAAA, 85};

    reset = 1'b1; start = 1'b0; ly = 8'h00; scx = 8'h00; scy = 8'h00;
    map_sel = 1'b0; data_sel = 1'b0; bus.fifo_ready = 1'b1;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init.addr", 32'(bus.vram_addr), 32'h0);
    chk("init.rd",   32'(bus.vram_rd),   32'h0);
    chk("init.push", 32'(bus.push),      32'h0);
    chk("init.px",   32'(bus.px),        32'h0);
    chk("init.busy", 32'(busy),          32'h0);
    chk("init.done", 32'(done),          32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      string t;
      t = $sformatf("vec%0d", v);
      fill_mem();
      poke(vecs[v].pa0, vecs[v].pd0);
      poke(vecs[v].pa1, vecs[v].pd1);
      poke(vecs[v].pa2, vecs[v].pd2);
      set_ready(vecs[v].stall, 1'b0);
      run_line(int'(vecs[v].ly), int'(vecs[v].scx), int'(vecs[v].scy), vecs[v].ms, vecs[v].ds,
               -1, 1'b0, 1'b0, t);
      chk({t, ".nreads"}, 32'(obs_reads.size()), 32'(3 * N));
      chk({t, ".a0"}, (obs_reads.size() > 0) ? 32'(obs_reads[0]) : 32'hFFFF_FFFF, 32'(vecs[v].ea0));
      chk({t, ".a1"}, (obs_reads.size() > 1) ? 32'(obs_reads[1]) : 32'hFFFF_FFFF, 32'(vecs[v].ea1));
      chk({t, ".a2"}, (obs_reads.size() > 2) ? 32'(obs_reads[2]) : 32'hFFFF_FFFF, 32'(vecs[v].ea2));
      chk({t, ".a3"}, (obs_reads.size() > 3) ? 32'(obs_reads[3]) : 32'hFFFF_FFFF, 32'(vecs[v].ea3));
      chk({t, ".px0"}, (obs_px.size() > 0) ? 32'(obs_px[0]) : 32'hFFFF_FFFF, 32'(vecs[v].epx));
      chk({t, ".npush"}, 32'(obs_px.size()), 32'(N));
      chk({t, ".cycles"}, 32'(obs_busy_cnt), 32'(vecs[v].ecyc));
    end

    // Reset in the middle of DATA_HI, with a start in the same cycle.
    fill_mem();
    poke(16'h9800, 8'h01); poke(16'h8010, 8'hFF); poke(16'h8011, 8'hFF);
    @(posedge clk); #1;
    start = 1'b1; ly = 8'h00; scx = 8'h00; scy = 8'h00; map_sel = 1'b0; data_sel = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst.pre_rd",   32'(bus.vram_rd),   32'h1);
    chk("rst.pre_addr", 32'(bus.vram_addr), 32'h8011);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1;
    ly = 8'h21; scx = 8'h10; scy = 8'h40; map_sel = 1'b1; data_sel = 1'b0;
    @(negedge clk);
    chk("rst.addr", 32'(bus.vram_addr), 32'h0);
    chk("rst.rd",   32'(bus.vram_rd),   32'h0);
    chk("rst.push", 32'(bus.push),      32'h0);
    chk("rst.px",   32'(bus.px),        32'h0);
    chk("rst.busy", 32'(busy),          32'h0);
    chk("rst.done", 32'(done),          32'h0);
    set_ready(0, 1'b0);
    run_line(32'h21, 32'h10, 32'h40, 1'b1, 1'b0, -1, 1'b0, 1'b1, "rst.line");
    chk("rst.npush", 32'(obs_px.size()), 32'(N));

    // Random lines: random backpressure, mid-line start pulse, inputs churning.
    for (int r = 0; r < 8; r++) begin
      string t;
      t = $sformatf("rnd%0d", r);
      fill_mem();
      set_ready(0, 1'b1);
      run_line(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
               1'($urandom), 1'($urandom), int'($urandom_range(60, 1)), 1'b1, 1'b0, t);
      chk({t, ".npush"},  32'(obs_px.size()),    32'(N));
      chk({t, ".nreads"}, 32'(obs_reads.size()), 32'(3 * N));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
